// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrated multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Increment an index and wrap to 0 at n. Works for any n, not only powers of two.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin from ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  input  logic            en,
  output logic [N-1:0]    gnt_onehot,
  output logic [SELW-1:0] gnt_idx,
  output logic            any
);

  logic [SELW:0]   w_sum;
  logic [SELW-1:0] w_idx;

  // Walk candidates in priority order; the first requesting one wins
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_sum      = '0;
    w_idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr is always < N, so one conditional subtract gives (ptr+k) mod N
      w_sum = {1'b0, ptr} + (SELW+1)'(k);
      if (w_sum >= (SELW+1)'(N)) begin
        w_sum = w_sum - (SELW+1)'(N);
      end
      w_idx = (mode == MODE_RR) ? w_sum[SELW-1:0] : SELW'(k);
      if (en && !any && req[w_idx]) begin
        any               = 1'b1;
        gnt_idx           = w_idx;
        gnt_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready multiplexer with internal arbitration and one output register.
module arb_mux
  import mux_pkg::*;
#(
  parameter  int unsigned N    = 4,
  parameter  int unsigned W    = 8,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [N-1:0]    in_valid,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel,
  input  logic            out_ready
);

  state_t          r_state;
  logic [W-1:0]    r_data;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_ptr;

  logic            w_load_en;
  logic            w_any;
  logic [N-1:0]    w_gnt;
  logic [SELW-1:0] w_gnt_idx;
  logic [W-1:0]    w_gnt_data;

  // Register may accept a new word when empty or when its word leaves this cycle
  assign w_load_en = (r_state == ST_EMPTY) || out_ready;

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req        (in_valid),
    .ptr        (r_ptr),
    .mode       (mode),
    .en         (w_load_en),
    .gnt_onehot (w_gnt),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  assign w_gnt_data = in_data[w_gnt_idx*W +: W];

  // Occupancy FSM with output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else if (w_load_en) begin
      if (w_any) begin
        // EMPTY->FULL, or FULL->FULL reload with no bubble
        r_state <= ST_FULL;
        r_data  <= w_gnt_data;
        r_sel   <= w_gnt_idx;
        if (mode == MODE_RR) begin
          r_ptr <= SELW'(wrap_inc(32'(w_gnt_idx), N));
        end
      end else begin
        // Word drained (or was never there) and nothing new to load
        r_state <= ST_EMPTY;
      end
    end
  end

  assign in_ready  = w_gnt;
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Directed + randomized bench for arb_mux (N=4 and N=3 instances).
module tb_arb_mux;

  logic        clk;
  logic        rst_n;

  logic        mode4, ordy4, ov4;
  logic [3:0]  v4, rdy4;
  logic [31:0] d4;
  logic [7:0]  od4;
  logic [1:0]  os4;

  logic        mode3, ordy3, ov3;
  logic [2:0]  v3, rdy3;
  logic [23:0] d3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit       e4_v, e3_v;
  bit [7:0] e4_d, e3_d;
  int       e4_s, e3_s, e4_p, e3_p;
  int       g4, g3;

  arb_mux #(.N(4), .W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode4), .in_valid(v4), .in_data(d4),
    .in_ready(rdy4), .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4)
  );

  arb_mux #(.N(3), .W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .in_valid(v3), .in_data(d3),
    .in_ready(rdy3), .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner among n channels: ascending from p (round-robin) or from 0 (fixed); -1 if none
  function automatic int pick(input int n, input logic [3:0] v, input logic m, input int p);
    for (int k = 0; k < n; k++) begin
      int c;
      c = m ? (p + k) % n : k;
      if (((v >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    e4_v = 0; e4_d = '0; e4_s = 0; e4_p = 0;
    e3_v = 0; e3_d = '0; e3_s = 0; e3_p = 0;
  endtask

  // One cycle: check in_ready before the edge, advance model, check outputs after it
  task automatic tick();
    #3;
    g4 = (!e4_v || ordy4) ? pick(4, v4, mode4, e4_p) : -1;
    g3 = (!e3_v || ordy3) ? pick(3, 4'(v3), mode3, e3_p) : -1;
    chk("rdy4", 32'(rdy4), (g4 >= 0) ? (32'd1 << g4) : 32'd0);
    chk("rdy3", 32'(rdy3), (g3 >= 0) ? (32'd1 << g3) : 32'd0);
    @(posedge clk);
    if (!e4_v || ordy4) begin
      if (g4 >= 0) begin
        e4_v = 1; e4_d = d4[g4*8 +: 8]; e4_s = g4;
        if (mode4) e4_p = (g4 + 1) % 4;
      end else e4_v = 0;
    end
    if (!e3_v || ordy3) begin
      if (g3 >= 0) begin
        e3_v = 1; e3_d = d3[g3*8 +: 8]; e3_s = g3;
        if (mode3) e3_p = (g3 + 1) % 3;
      end else e3_v = 0;
    end
    #1;
    chk("ov4", 32'(ov4), 32'(e4_v));
    chk("ov3", 32'(ov3), 32'(e3_v));
    if (e4_v) begin
      chk("od4", 32'(od4), 32'(e4_d));
      chk("os4", 32'(os4), 32'(e4_s));
    end
    if (e3_v) begin
      chk("od3", 32'(od3), 32'(e3_d));
      chk("os3", 32'(os3), 32'(e3_s));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mode4 = 1'b0; ordy4 = 1'b0; v4 = '0; d4 = '0;
    mode3 = 1'b0; ordy3 = 1'b0; v3 = '0; d3 = '0;
    model_reset();

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov", 32'(ov4), 32'd0);
    chk("rst_od", 32'(od4), 32'd0);
    chk("rst_os", 32'(os4), 32'd0);
    chk("rst_rdy", 32'(rdy4), 32'd0);
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      chk("idle_od", 32'(od4), 32'd0);
    end

    // Fixed priority: ch1 beats ch3 while held
    mode4 = 1'b0; ordy4 = 1'b1; v4 = 4'b1010;
    d4 = {8'hA3, 8'h00, 8'hA1, 8'h00};
    repeat (4) begin
      tick();
      chk("fix_d1", 32'(od4), 32'hA1);
      chk("fix_s1", 32'(os4), 32'd1);
    end
    v4 = 4'b1000;
    tick();
    chk("fix_d3", 32'(od4), 32'hA3);
    chk("fix_s3", 32'(os4), 32'd3);

    // Round-robin rotation, one word per cycle; ptr still 0 after fixed mode
    mode4 = 1'b1; v4 = 4'b1111;
    d4 = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_sel", 32'(os4), 32'(i % 4));
      chk("rr_val", 32'(ov4), 32'd1);
    end

    // Backpressure holds 0x5C, then reload without a bubble
    v4 = '0;
    tick();
    mode4 = 1'b0; ordy4 = 1'b0; v4 = 4'b0001; d4 = 32'h0000_005C;
    tick();
    chk("bp_load", 32'(od4), 32'h5C);
    d4 = 32'h0000_0077;
    repeat (5) begin
      tick();
      chk("bp_hold_d", 32'(od4), 32'h5C);
      chk("bp_hold_s", 32'(os4), 32'd0);
      chk("bp_rdy", 32'(rdy4), 32'd0);
    end
    ordy4 = 1'b1;
    tick();
    chk("bp_nobub_v", 32'(ov4), 32'd1);
    chk("bp_nobub_d", 32'(od4), 32'h77);
    v4 = '0;
    tick();

    // Non-power-of-two wrap on N=3
    mode3 = 1'b1; ordy3 = 1'b1; v3 = 3'b111;
    d3 = {8'hC2, 8'hC1, 8'hC0};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("n3_sel", 32'(os3), 32'(i % 3));
      chk("n3_dat", 32'(od3), 32'(8'hC0 + 8'(i % 3)));
    end
    v3 = '0;
    tick();

    // Asynchronous reset mid-stream, round-robin restarts at channel 0
    mode4 = 1'b1; v4 = 4'b1111; ordy4 = 1'b1;
    d4 = {8'h33, 8'h22, 8'h11, 8'h00};
    tick();
    tick();
    chk("ar_pre", 32'(ov4), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_ov", 32'(ov4), 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    tick();
    chk("ar_sel0", 32'(os4), 32'd0);
    tick();
    chk("ar_sel1", 32'(os4), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      mode4 = 1'($urandom);
      v4    = 4'($urandom);
      d4    = $urandom;
      ordy4 = ($urandom_range(3) != 0);
      mode3 = 1'($urandom);
      v3    = 3'($urandom);
      d3    = 24'($urandom);
      ordy3 = ($urandom_range(3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
